// File: rtl/jk_flip_flop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jk_flip_flop : bank of WIDTH independent JK flops with complementary outputs
// Optional macro JK_FF_HOLD_EN adds a global hold enable input "en".
// Revision 1.0
// ----------------------------------------------------------------------------
module jk_flip_flop #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
`ifdef JK_FF_HOLD_EN
  input  logic               en,
`endif
  input  logic [2*WIDTH-1:0] state,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_bar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_en;

`ifdef JK_FF_HOLD_EN
  assign w_en = en;
`else
  assign w_en = 1'b1;
`endif

  // Characteristic equation q+ = J&~q | ~K&q keeps X commands visible as X.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_j;
    logic w_k;
    assign w_j       = state[2*i+1];
    assign w_k       = state[2*i];
    assign w_next[i] = (w_j & ~r_q[i]) | (~w_k & r_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (w_en) begin
      r_q <= w_next;
    end
  end

  assign q     = r_q;
  assign q_bar = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_flip_flop.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jk_flip_flop : directed plus randomized check of a 2-cell JK flop bank
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_jk_flip_flop;
  localparam int         W   = 2;
  localparam logic [1:0] RSV = 2'b00;

  logic         clk;
  logic         rst;
  logic         en;
  logic [2*W-1:0] state;
  logic [W-1:0] q;
  logic [W-1:0] q_bar;

  int n_checks;
  int n_fail;

  jk_flip_flop #(.WIDTH(W), .RST_VAL(RSV)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef JK_FF_HOLD_EN
    .en    (en),
`endif
    .state (state),
    .q     (q),
    .q_bar (q_bar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each cell obeys the hold/clear/set/toggle command table.
  logic [W-1:0] mq;
  logic         en_m;
`ifdef JK_FF_HOLD_EN
  assign en_m = en;
`else
  assign en_m = 1'b1;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq <= RSV;
    end else if (en_m) begin
      for (int i = 0; i < W; i++) begin
        case (state[2*i +: 2])
          2'd1:    mq[i] <= 1'b0;
          2'd2:    mq[i] <= 1'b1;
          2'd3:    mq[i] <= ~mq[i];
          default: mq[i] <= mq[i];
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_q", q, mq);
    chk("model_qbar", q_bar, ~mq);
  end

  task automatic step(input logic [2*W-1:0] st);
    state = st;
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    en       = 1'b1;
    state    = '0;

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("reset_async_q", q, 2'b00);
    chk("reset_async_qbar", q_bar, 2'b11);
    state = 4'b1111;
    @(negedge clk);
    chk("reset_hold_q", q, 2'b00);
    rst = 1'b0;

    step(4'b0000); chk("hold1", q, 2'b00);
    step(4'b0000); chk("hold2", q, 2'b00);
    chk("hold2_qbar", q_bar, 2'b11);
    step(4'b0001); chk("clear", q, 2'b00);
    step(4'b0010); chk("set", q, 2'b01);
    chk("set_qbar", q_bar, 2'b10);

    step(4'b0011); chk("tog1", q, 2'b00);
    step(4'b0011); chk("tog2", q, 2'b01);
    step(4'b0011); chk("tog3", q, 2'b00);
    step(4'b0011); chk("tog4", q, 2'b01);

    // Reset between edges while toggling
    #2 rst = 1'b1;
    #1;
    chk("midtog_rst_q", q, 2'b00);
    chk("midtog_rst_qbar", q_bar, 2'b11);
    @(negedge clk);
    chk("midtog_rst_held", q, 2'b00);
    #1 rst = 1'b0;
    @(negedge clk); chk("resume1", q, 2'b01);
    @(negedge clk); chk("resume2", q, 2'b00);

    // Multi-cell: cell1 set, cell0 toggle
    step(4'b1011); chk("multi1", q, 2'b11);
    step(4'b1011); chk("multi2", q, 2'b10);
    chk("multi2_qbar", q_bar, 2'b01);

`ifdef JK_FF_HOLD_EN
    en = 1'b0;
    step(4'b0111); chk("en_hold1", q, 2'b10);
    step(4'b1111); chk("en_hold2", q, 2'b10);
    #2 rst = 1'b1;
    #1 chk("en_rst", q, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
`endif

    // Randomized stimulus with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst   = 1'b0;
      state = 4'($urandom);
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        #2 rst = 1'b1;
        #1 chk("rnd_async_rst", q, RSV);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
